// File: rtl/ysyx_24110006_ifu_pkg.sv
// Shared definitions for the ysyx_24110006 instruction fetch unit: state encoding,
// reset PC default and the instruction word substituted for faulted fetches.
package ysyx_24110006_ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ERR_INST     = 32'h0000_0000;
  localparam int unsigned INST_BYTES   = 4;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24110006_ifu_perf.sv
// Performance counters for the fetch unit: decode handshakes and cycles spent
// waiting on memory. Only instantiated when YSYX_24110006_IFU_PERF_EN is defined.
module ysyx_24110006_ifu_perf (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        fetch_i,
  input  logic        wait_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  // Free-running wrapping counters.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fetch_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (fetch_i) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if (wait_i) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: one outstanding word fetch, {pc, inst} handed to decode over
// valid/ready, redirects from execute. Optional counters under YSYX_24110006_IFU_PERF_EN.
module ysyx_24110006_ifu
  import ysyx_24110006_ifu_pkg::*;
#(
  parameter int unsigned           XLEN     = 32,
  parameter logic [XLEN-1:0]       RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  output logic            o_mem_valid,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [31:0]     i_mem_rdata,
  input  logic            i_mem_err,
  output logic            o_inst_valid,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_fetch_err,
  input  logic            i_inst_ready,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc
`ifdef YSYX_24110006_IFU_PERF_EN
  ,
  output logic [31:0]     o_perf_fetch_cnt,
  output logic [31:0]     o_perf_stall_cnt
`endif
);

  ifu_state_e      state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            err_q;
  logic            kill_q;

  logic mem_fire_s;
  logic dec_fire_s;
  logic redir_mis_s;
  logic in_flight_s;

  // A pending kill holds off new requests until the stale response has drained.
  assign o_mem_valid  = (state_q == ST_REQ) && !kill_q && !i_reset;
  assign o_mem_addr   = pc_q;
  assign mem_fire_s   = o_mem_valid && i_mem_ready;
  assign o_inst_valid = (state_q == ST_HOLD) && !i_redirect_valid && !i_reset;
  assign dec_fire_s   = o_inst_valid && i_inst_ready;
  assign o_inst       = i_reset ? ERR_INST : inst_q;
  assign o_pc         = pc_q;
  assign o_fetch_err  = err_q && !i_reset;
  assign redir_mis_s  = is_misaligned(i_redirect_pc[1:0]);
  assign in_flight_s  = mem_fire_s || ((state_q == ST_WAIT) && !i_mem_rvalid);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= ERR_INST;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      if (kill_q && i_mem_rvalid) begin
        kill_q <= 1'b0;
      end
      if (i_redirect_valid) begin
        pc_q <= i_redirect_pc;
        if (redir_mis_s) begin
          state_q <= ST_HOLD;
          inst_q  <= ERR_INST;
          err_q   <= 1'b1;
          if (in_flight_s) begin
            kill_q <= 1'b1;
          end
        end else begin
          case (state_q)
            ST_REQ: begin
              if (mem_fire_s) begin
                kill_q  <= 1'b1;
                state_q <= ST_WAIT;
              end else begin
                state_q <= ST_REQ;
              end
            end
            ST_WAIT: begin
              if (i_mem_rvalid) begin
                state_q <= ST_REQ;
              end else begin
                kill_q  <= 1'b1;
                state_q <= ST_WAIT;
              end
            end
            ST_HOLD: state_q <= ST_REQ;
            default: state_q <= ST_REQ;
          endcase
        end
      end else begin
        case (state_q)
          ST_REQ: begin
            if (mem_fire_s) begin
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (i_mem_rvalid) begin
              if (kill_q) begin
                state_q <= ST_REQ;
              end else begin
                inst_q  <= i_mem_err ? ERR_INST : i_mem_rdata;
                err_q   <= i_mem_err;
                state_q <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (dec_fire_s) begin
              pc_q    <= pc_q + XLEN'(INST_BYTES);
              state_q <= ST_REQ;
            end
          end
          default: state_q <= ST_REQ;
        endcase
      end
    end
  end

`ifdef YSYX_24110006_IFU_PERF_EN
  ysyx_24110006_ifu_perf u_perf (
    .clock_i     (i_clock),
    .reset_i     (i_reset),
    .fetch_i     (dec_fire_s),
    .wait_i      (state_q == ST_WAIT),
    .fetch_cnt_o (o_perf_fetch_cnt),
    .stall_cnt_o (o_perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Scoreboard bench for ysyx_24110006_ifu: the next instruction decode should see is
// derived from the PC alone (memory contents and faults are functions of address).
module tb_ysyx_24110006_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_mem_valid;
  logic [31:0] o_mem_addr;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = 32'h0;
  logic        i_mem_err = 1'b0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_fetch_err;
  logic        i_inst_ready = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
`ifdef YSYX_24110006_IFU_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  ysyx_24110006_ifu #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .o_mem_valid      (o_mem_valid),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ready      (i_mem_ready),
    .i_mem_rvalid     (i_mem_rvalid),
    .i_mem_rdata      (i_mem_rdata),
    .i_mem_err        (i_mem_err),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_pc             (o_pc),
    .o_fetch_err      (o_fetch_err),
    .i_inst_ready     (i_inst_ready),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc)
`ifdef YSYX_24110006_IFU_PERF_EN
    ,
    .o_perf_fetch_cnt (perf_fetch),
    .o_perf_stall_cnt (perf_stall)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  int          hs_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_hs = 0;
  int          cycle = 0;

  int          k_rdy_pct = 100;
  int          k_lat = 1;
  int          k_dec_pct = 100;
  int          k_redir_pct = 0;
  logic        k_reset = 1'b1;
  logic        d_redir = 1'b0;
  logic [31:0] d_target = 32'h0;
  logic        d_stale = 1'b0;

  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic mem_fault(input logic [31:0] a);
    return a[7:2] == 6'h2a;
  endfunction

  function automatic exp_t expect_at(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.err  = (pc[1:0] != 2'b00) || mem_fault(pc);
    e.inst = e.err ? 32'h0 : mem_word(pc);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock: drive inputs just after the edge, observe memory handshakes at negedge.
  task automatic step();
    logic f;
    @(posedge clk);
    #1;
    cycle++;
    i_reset = k_reset;
    if (k_reset) begin
      i_redirect_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back(expect_at(RST_PC));
    end else if (d_redir || ($urandom_range(99) < k_redir_pct)) begin
      i_redirect_valid = 1'b1;
      i_redirect_pc = d_redir ? d_target : RST_PC + ($urandom_range(255) << 2);
      d_redir = 1'b0;
      exp_q.delete();
      exp_q.push_back(expect_at(i_redirect_pc));
    end else begin
      i_redirect_valid = 1'b0;
      i_redirect_pc = $urandom;
    end
    i_inst_ready = ($urandom_range(99) < k_dec_pct);
    i_mem_rvalid = 1'b0;
    i_mem_err = $urandom_range(1);
    i_mem_rdata = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        i_mem_rvalid = 1'b1;
        if (d_stale) begin
          i_mem_rdata = 32'hDEAD_BEEF;
          i_mem_err = 1'b0;
          d_stale = 1'b0;
        end else begin
          f = mem_fault(pend_addr);
          i_mem_err = f;
          i_mem_rdata = f ? $urandom : mem_word(pend_addr);
        end
      end
    end
    i_mem_ready = !pend && ($urandom_range(99) < k_rdy_pct);
    @(negedge clk);
    if (i_mem_rvalid) pend = 1'b0;
    if (o_mem_valid && i_mem_ready) begin
      pend = 1'b1;
      pend_cnt = k_lat;
      pend_addr = o_mem_addr;
      acc_q.push_back(o_mem_addr);
    end
  endtask

  task automatic wait_accept(input int n0, input string name);
    int b = 0;
    while (acc_q.size() <= n0 && b < 60) begin step(); b++; end
    if (acc_q.size() <= n0) timeout(name);
  endtask

  task automatic wait_hs(input int n0, input string name);
    int b = 0;
    while (n_hs <= n0 && b < 60) begin step(); b++; end
    if (n_hs <= n0) timeout(name);
  endtask

  task automatic wait_inst_valid(input string name);
    int b = 0;
    while (!o_inst_valid && b < 60) begin step(); b++; end
    if (!o_inst_valid) timeout(name);
  endtask

  exp_t        mon_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  // Monitor: compares every decode handshake with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset) begin
        check("rst_mem_valid", o_mem_valid, 1'b0);
        check("rst_inst_valid", o_inst_valid, 1'b0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_fetch_err", o_fetch_err, 1'b0);
      end else begin
        if (i_redirect_valid) check("redir_blocks_valid", o_inst_valid, 1'b0);
        if (o_mem_valid) check("addr_aligned", o_mem_addr[1:0], 2'b00);
        if (prev_stall) begin
          check("req_held_valid", o_mem_valid, 1'b1);
          check("req_held_addr", o_mem_addr, prev_addr);
        end
        if (o_inst_valid && i_inst_ready) begin
          n_hs++;
          hs_cyc.push_back(cycle);
          if (exp_q.size() == 0) begin
            timeout("hs_unexpected");
          end else begin
            mon_e = exp_q.pop_front();
            check("hs_pc", o_pc, mon_e.pc);
            check("hs_inst", o_inst, mon_e.inst);
            check("hs_err", o_fetch_err, mon_e.err);
            exp_q.push_back(expect_at(mon_e.pc + 32'd4));
          end
        end
      end
      prev_stall = !i_reset && o_mem_valid && !i_mem_ready && !i_redirect_valid;
      prev_addr = o_mem_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          n0;
  int          nh0;
  logic [31:0] held_pc;
  logic [31:0] held_inst;
`ifdef YSYX_24110006_IFU_PERF_EN
  logic [31:0] pf0;
  logic [31:0] ps0;
`endif

  initial begin
    k_reset = 1'b1;
    repeat (3) step();
    k_reset = 1'b0;
    acc_q.delete();
    hs_cyc.delete();
    step();
    check("first_req_valid", o_mem_valid, 1'b1);
    check("first_req_addr", o_mem_addr, RST_PC);
    repeat (9) step();
    check("thr_accept_count", acc_q.size() >= 3, 1'b1);
    check("thr_hs_count", hs_cyc.size() >= 3, 1'b1);
    if (acc_q.size() >= 3 && hs_cyc.size() >= 3) begin
      check("thr_addr0", acc_q[0], 32'h8000_0000);
      check("thr_addr1", acc_q[1], 32'h8000_0004);
      check("thr_addr2", acc_q[2], 32'h8000_0008);
      check("thr_gap01", hs_cyc[1] - hs_cyc[0], 3);
      check("thr_gap12", hs_cyc[2] - hs_cyc[1], 3);
    end

    // Decode stalls in HOLD.
    k_dec_pct = 0;
    wait_inst_valid("stall_hold");
    held_pc = o_pc;
    held_inst = o_inst;
    n0 = acc_q.size();
    repeat (5) begin
      step();
      check("stall_pc", o_pc, held_pc);
      check("stall_inst", o_inst, held_inst);
      check("stall_valid", o_inst_valid, 1'b1);
      check("stall_no_req", o_mem_valid, 1'b0);
    end
    check("stall_no_accept", acc_q.size(), n0);
    k_dec_pct = 100;
    wait_accept(n0, "stall_next");
    if (acc_q.size() > n0) check("stall_next_addr", acc_q[n0], held_pc + 32'd4);

    // Redirect while waiting on memory; the stale response is poisoned.
    k_lat = 3;
    n0 = acc_q.size();
    wait_accept(n0, "wr_acc");
    d_redir = 1'b1;
    d_target = 32'h8000_0100;
    d_stale = 1'b1;
    step();
    n0 = acc_q.size();
    wait_accept(n0, "wr_next");
    if (acc_q.size() > n0) check("wr_next_addr", acc_q[n0], 32'h8000_0100);

    // Redirect in HOLD together with decode ready.
    k_lat = 1;
    k_dec_pct = 0;
    wait_inst_valid("hr_hold");
    k_dec_pct = 100;
    d_redir = 1'b1;
    d_target = 32'h8000_0200;
    nh0 = n_hs;
    n0 = acc_q.size();
    step();
    check("hr_no_hs", n_hs, nh0);
    wait_accept(n0, "hr_next");
    if (acc_q.size() > n0) check("hr_next_addr", acc_q[n0], 32'h8000_0200);

    // Bus error fetch, then a misaligned redirect.
    d_redir = 1'b1;
    d_target = 32'h8000_00A8;
    step();
    nh0 = n_hs;
    wait_hs(nh0, "err_hs");
    check("err_flag", o_fetch_err, 1'b1);
    check("err_inst", o_inst, 32'h0);
    k_dec_pct = 0;
    d_redir = 1'b1;
    d_target = 32'h8000_0102;
    step();
    n0 = acc_q.size();
    step();
    check("mis_valid", o_inst_valid, 1'b1);
    check("mis_err", o_fetch_err, 1'b1);
    check("mis_pc", o_pc, 32'h8000_0102);
    check("mis_inst", o_inst, 32'h0);
    repeat (3) begin
      step();
      check("mis_no_req", o_mem_valid, 1'b0);
    end
    check("mis_no_accept", acc_q.size(), n0);
    d_redir = 1'b1;
    d_target = RST_PC;
    step();
    k_dec_pct = 100;

`ifdef YSYX_24110006_IFU_PERF_EN
    k_lat = 2;
    wait_hs(n_hs, "perf_settle");
    wait_hs(n_hs, "perf_h0");
    pf0 = perf_fetch;
    ps0 = perf_stall;
    repeat (10) wait_hs(n_hs, "perf_run");
    check("perf_fetch", perf_fetch - pf0, 32'd10);
    check("perf_stall", perf_stall - ps0, 32'd20);
`endif

    // Randomized traffic with redirects and occasional mid-transaction resets.
    nh0 = n_hs;
    k_redir_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      k_rdy_pct = $urandom_range(100, 30);
      k_lat = $urandom_range(4, 1);
      k_dec_pct = $urandom_range(100, 20);
      k_reset = ($urandom_range(499) == 0);
      step();
    end
    k_reset = 1'b0;
    k_redir_pct = 0;
    k_dec_pct = 100;
    k_rdy_pct = 100;
    repeat (20) step();
    check("rand_progress", n_hs - nh0 > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
